// File: rtl/controlwrite.sv
// controlwrite: receive-side frame assembler.
// Collects bytes from the UART receiver into an NBYTES-deep message buffer,
// raises frame_valid once a whole frame is stored and holds it until the
// consumer acknowledges. Partial frames are dropped on a receiver error or
// when the gap between bytes exceeds TIMEOUT ticks; bytes arriving while a
// completed frame is still pending are dropped and reported as overrun.
module controlwrite #(
  parameter int NBYTES  = 6,
  parameter int AW      = 3,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic          tickbd,
  input  logic          rst,
  input  logic          rxdone,
  input  logic [7:0]    rxdata,
  input  logic          rxerr,
  input  logic          frame_ack,
  output logic [AW-1:0] addr,
  output logic [7:0]    wdata,
  output logic          wrena,
  output logic          frame_valid,
  output logic          frame_err,
  output logic          overrun
);

  localparam int DATA_W = 8;

  // IDLE: nothing collected yet, RECV: frame in progress with gap timer,
  // LAST: final byte just written, FULL: frame held until acknowledged.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  // Index of the final byte of a frame and the last tolerated idle count.
  localparam logic [AW-1:0] LAST_IDX = AW'(NBYTES - 1);
  localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wrena_q, wrena_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  // Next-state and output decode for the frame assembler.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmr_d         = tmr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wrena_d       = 1'b0;
    frame_valid_d = frame_valid_q;
    frame_err_d   = 1'b0;
    overrun_d     = 1'b0;

    case (state_q)
      S_IDLE, S_RECV: begin
        if (rxerr) begin
          // A receiver error discards whatever was collected, even if the
          // faulty byte came with rxdone; the pulse is reported in IDLE too.
          frame_err_d = 1'b1;
          cnt_d       = '0;
          tmr_d       = '0;
          state_d     = S_IDLE;
        end else if (rxdone) begin
          wrena_d = 1'b1;
          addr_d  = cnt_q;
          wdata_d = rxdata;
          tmr_d   = '0;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = S_LAST;
          end else begin
            cnt_d   = cnt_q + AW'(1);
            state_d = S_RECV;
          end
        end else if (state_q == S_RECV) begin
          // Gap timer only runs once a frame has started; a byte in the
          // same cycle as expiry wins because it is handled above.
          if (tmr_q == TMR_MAX) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
            tmr_d       = '0;
            state_d     = S_IDLE;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
      end

      S_LAST: begin
        // The final write is already out, so frame_valid rises strictly
        // after it.
        frame_valid_d = 1'b1;
        state_d       = S_FULL;
        if (rxdone) begin
          overrun_d = 1'b1;
        end
      end

      S_FULL: begin
        // Buffer is owned by the consumer: new bytes are dropped and
        // receiver errors are irrelevant.
        if (rxdone) begin
          overrun_d = 1'b1;
        end
        if (frame_ack) begin
          frame_valid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tmr_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge tickbd or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tmr_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wrena_q       <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wrena_q       <= wrena_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign wrena       = wrena_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_controlwrite.sv
// Testbench for controlwrite: table-driven vectors, directed corner-case
// sequences and randomized traffic checked against a frame-level model.
module tb_controlwrite;

  localparam int NB = 6;
  localparam int AW = 3;
  localparam int TO = 1023;
  localparam int TW = 10;

  logic          tickbd = 1'b0;
  logic          rst    = 1'b1;
  logic          rxdone = 1'b0;
  logic [7:0]    rxdata = 8'h00;
  logic          rxerr  = 1'b0;
  logic          frame_ack = 1'b0;
  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic          wrena, frame_valid, frame_err, overrun;

  logic          rxdone2 = 1'b0;
  logic [7:0]    rxdata2 = 8'h00;
  logic          rxerr2  = 1'b0;
  logic          frame_ack2 = 1'b0;
  logic [AW-1:0] addr2;
  logic [7:0]    wdata2;
  logic          wrena2, frame_valid2, frame_err2, overrun2;

  int checks = 0;
  int errors = 0;

  always #5 tickbd = ~tickbd;

  controlwrite #(.NBYTES(NB), .AW(AW), .TIMEOUT(TO), .TW(TW)) dut (
    .tickbd(tickbd), .rst(rst), .rxdone(rxdone), .rxdata(rxdata),
    .rxerr(rxerr), .frame_ack(frame_ack), .addr(addr), .wdata(wdata),
    .wrena(wrena), .frame_valid(frame_valid), .frame_err(frame_err),
    .overrun(overrun)
  );

  controlwrite #(.NBYTES(1), .AW(AW), .TIMEOUT(TO), .TW(TW)) dut1 (
    .tickbd(tickbd), .rst(rst), .rxdone(rxdone2), .rxdata(rxdata2),
    .rxerr(rxerr2), .frame_ack(frame_ack2), .addr(addr2), .wdata(wdata2),
    .wrena(wrena2), .frame_valid(frame_valid2), .frame_err(frame_err2),
    .overrun(overrun2)
  );

  // Frame-level reference model: bytes stored so far, idle ticks since the
  // last byte, and whether a completed frame is pending/held.
  int         m_stored, m_silence, m_addr;
  bit         m_pending, m_fv, m_wr, m_err, m_ovr;
  logic [7:0] m_wdata;

  task automatic model_reset();
    m_stored = 0; m_silence = 0; m_addr = 0; m_wdata = 8'h00;
    m_pending = 0; m_fv = 0; m_wr = 0; m_err = 0; m_ovr = 0;
  endtask

  task automatic model_step(input logic rd, input logic [7:0] d,
                            input logic er, input logic ak);
    m_wr = 0; m_err = 0; m_ovr = 0;
    if (m_pending) begin
      m_fv = 1; m_pending = 0;
      if (rd) m_ovr = 1;
    end else if (m_fv) begin
      if (rd) m_ovr = 1;
      if (ak) m_fv = 0;
    end else if (er) begin
      m_err = 1; m_stored = 0; m_silence = 0;
    end else if (rd) begin
      m_wr = 1; m_addr = m_stored; m_wdata = d; m_silence = 0;
      m_stored = m_stored + 1;
      if (m_stored == NB) begin
        m_stored = 0; m_pending = 1;
      end
    end else if (m_stored > 0) begin
      m_silence = m_silence + 1;
      if (m_silence == TO) begin
        m_err = 1; m_stored = 0; m_silence = 0;
      end
    end
  endtask

  function automatic logic [14:0] mk(input int a, input logic [7:0] d,
                                     input logic wr, input logic fv,
                                     input logic er, input logic ov);
    logic [AW-1:0] a_t;
    a_t = AW'(a);
    return {a_t, d, wr, fv, er, ov};
  endfunction

  function automatic logic [14:0] outv();
    return {addr, wdata, wrena, frame_valid, frame_err, overrun};
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, let the edge happen, then compare everything
  // against the model a little after the edge.
  task automatic cyc(input logic rd, input logic [7:0] d, input logic er,
                     input logic ak);
    rxdone = rd; rxdata = d; rxerr = er; frame_ack = ak;
    @(posedge tickbd);
    #1;
    model_step(rd, d, er, ak);
    chk("model", 32'(outv()), 32'(mk(m_addr, m_wdata, m_wr, m_fv, m_err, m_ovr)));
    rxdone = 1'b0; rxerr = 1'b0; frame_ack = 1'b0;
  endtask

  // Return to IDLE with an empty frame whatever the current state.
  task automatic flush();
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        rd;
    logic [7:0]  d;
    logic        er;
    logic        ak;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n;
    bit seen;

    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, mk(0, 8'h11, 1, 0, 0, 0)};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, mk(0, 8'h11, 0, 0, 0, 0)};
    tbl[2]  = '{1'b1, 8'h22, 1'b0, 1'b0, mk(1, 8'h22, 1, 0, 0, 0)};
    tbl[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, mk(2, 8'h33, 1, 0, 0, 0)};
    tbl[4]  = '{1'b1, 8'h44, 1'b0, 1'b0, mk(3, 8'h44, 1, 0, 0, 0)};
    tbl[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, mk(4, 8'h55, 1, 0, 0, 0)};
    tbl[6]  = '{1'b1, 8'h66, 1'b0, 1'b0, mk(5, 8'h66, 1, 0, 0, 0)};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, mk(5, 8'h66, 0, 1, 0, 0)};
    tbl[8]  = '{1'b1, 8'h77, 1'b0, 1'b0, mk(5, 8'h66, 0, 1, 0, 1)};
    tbl[9]  = '{1'b1, 8'h88, 1'b0, 1'b1, mk(5, 8'h66, 0, 0, 0, 1)};
    tbl[10] = '{1'b1, 8'hA5, 1'b0, 1'b0, mk(0, 8'hA5, 1, 0, 0, 0)};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, mk(0, 8'hA5, 0, 0, 1, 0)};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, mk(0, 8'hA5, 0, 0, 1, 0)};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, mk(0, 8'hA5, 0, 0, 0, 0)};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, mk(0, 8'hA5, 0, 0, 0, 0)};
    tbl[15] = '{1'b1, 8'h5A, 1'b0, 1'b0, mk(0, 8'h5A, 1, 0, 0, 0)};

    // Reset state
    model_reset();
    repeat (3) @(posedge tickbd);
    #1;
    chk("reset_outputs", 32'(outv()), 32'h0);
    chk("reset_outputs_n1", 32'({addr2, wdata2, wrena2, frame_valid2, frame_err2, overrun2}), 32'h0);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rd, tbl[i].d, tbl[i].er, tbl[i].ak);
      chk($sformatf("vec%0d", i), 32'(outv()), 32'(tbl[i].exp));
    end
    flush();

    // Six bytes three idle cycles apart, frame_valid timing, ack, next byte
    for (int b = 0; b < NB; b++) begin
      cyc(1'b1, 8'(8'h11 * (b + 1)), 1'b0, 1'b0);
      chk("six_wr", 32'({wrena, addr, wdata}), 32'({1'b1, 3'(b), 8'(8'h11 * (b + 1))}));
      if (b == NB - 1) chk("six_fv_k1", 32'(frame_valid), 32'h0);
      else repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("six_fv_k2", 32'(frame_valid), 32'h1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("six_fv_ack", 32'(frame_valid), 32'h0);
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("six_after_ack", 32'({wrena, addr, wdata}), 32'({1'b1, 3'd0, 8'hA5}));
    flush();

    // Timeout after three bytes
    for (int b = 0; b < 3; b++) cyc(1'b1, 8'(8'hB0 + b), 1'b0, 1'b0);
    n = 1;
    seen = 0;
    while (n < TO + 50 && !seen) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
      if (frame_err) seen = 1;
    end
    chk("timeout_seen", 32'(seen), 32'h1);
    chk("timeout_cycles", 32'(n), 32'(TO + 1));
    cyc(1'b1, 8'hC1, 1'b0, 1'b0);
    chk("timeout_restart", 32'({wrena, addr, wdata}), 32'({1'b1, 3'd0, 8'hC1}));
    flush();

    // Byte arriving on the very last tolerated tick
    for (int b = 0; b < 3; b++) cyc(1'b1, 8'(8'hD0 + b), 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < TO - 1; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      if (frame_err) seen = 1;
    end
    cyc(1'b1, 8'hD3, 1'b0, 1'b0);
    if (frame_err) seen = 1;
    chk("edge_no_err", 32'(seen), 32'h0);
    chk("edge_accept", 32'({wrena, addr, wdata}), 32'({1'b1, 3'd3, 8'hD3}));
    flush();

    // Receiver error together with the fourth byte
    for (int b = 0; b < 3; b++) cyc(1'b1, 8'(8'hE0 + b), 1'b0, 1'b0);
    cyc(1'b1, 8'hE3, 1'b1, 1'b0);
    chk("rxerr_nowrite", 32'({wrena, frame_err}), 32'h1);
    cyc(1'b1, 8'hE4, 1'b0, 1'b0);
    chk("rxerr_restart", 32'({wrena, addr, wdata}), 32'({1'b1, 3'd0, 8'hE4}));
    flush();

    // Overrun while the frame is held
    for (int b = 0; b < NB; b++) cyc(1'b1, 8'(8'hF0 + b), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 8'h99, 1'b0, 1'b0);
      if (overrun && !wrena && frame_valid) n++;
    end
    chk("overrun_two", 32'(n), 32'h2);
    cyc(1'b1, 8'h98, 1'b0, 1'b1);
    chk("overrun_with_ack", 32'({wrena, frame_valid, overrun}), 32'h1);
    flush();

    // Asynchronous reset in the middle of a frame
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_async", 32'(outv()), 32'h0);
    repeat (2) @(posedge tickbd);
    #1;
    rst = 1'b0;
    model_reset();
    for (int b = 0; b < NB; b++) begin
      cyc(1'b1, 8'(8'h40 + b), 1'b0, 1'b0);
      chk("rst_frame", 32'({wrena, addr, wdata}), 32'({1'b1, 3'(b), 8'(8'h40 + b)}));
    end
    flush();

    // Single-byte frames
    for (int i = 0; i < 2; i++) begin
      rxdone2 = 1'b1; rxdata2 = 8'(8'hC3 + i);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      rxdone2 = 1'b0;
      chk("n1_write", 32'({wrena2, addr2, wdata2, frame_valid2}),
          32'({1'b1, 3'd0, 8'(8'hC3 + i), 1'b0}));
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("n1_valid", 32'({wrena2, frame_valid2}), 32'h1);
      frame_ack2 = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      frame_ack2 = 1'b0;
      chk("n1_ack", 32'(frame_valid2), 32'h0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 2) == 0), 8'($urandom),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlwrite.md
# controlwrite

Receive-side frame assembler for the UART datapath. Accepts bytes from the UART receiver (one `rxdone` pulse per byte), writes them into a NBYTES-deep message buffer at incrementing addresses, and raises `frame_valid` when a full frame is stored. Aborts partial frames on receiver error or inter-byte timeout, and flags bytes that arrive while the completed frame is still unacknowledged. It is the write-side counterpart of the transmit-side buffer reader and shares the same byte-tick clock domain.

## Interface
- `NBYTES`, 6, bytes per frame; legal range 1..2^AW
- `AW`, 3, address width
- `TIMEOUT`, 1023, maximum idle ticks allowed between bytes inside a frame; must be ≥ 2
- `TW`, 10, timer width; must satisfy 2^TW > TIMEOUT

- `tickbd`  in  1  clock; all logic is on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rxdone`  in  1  single-cycle pulse; `rxdata` is valid in that cycle
- `rxdata`  in  8  received byte
- `rxerr`  in  1  receiver framing error, single-cycle pulse; may coincide with `rxdone`
- `frame_ack`  in  1  consumer has read the frame; sampled only in FULL
- `addr`  out  AW  buffer write address
- `wdata`  out  8  buffer write data
- `wrena`  out  1  buffer write strobe, one cycle per stored byte
- `frame_valid`  out  1  level; a complete frame is in the buffer
- `frame_err`  out  1  single-cycle pulse; the partial frame was discarded
- `overrun`  out  1  single-cycle pulse; a byte was dropped in FULL

## Operation
- States: IDLE (no frame in progress), RECV (frame in progress, timer running), LAST (final byte written), FULL (waiting for `frame_ack`).
- Internal byte counter `cnt` (AW bits) and timer `tmr` (TW bits).
- Reset: state IDLE, `cnt`=0, `tmr`=0. `addr`, `wdata`, `wrena`, `frame_valid`, `frame_err` and `overrun` are all 0.
- `wrena`, `frame_err` and `overrun` default to 0 on every edge unless set below.
- Byte accepted (IDLE or RECV, `rxdone`=1, `rxerr`=0):
  - Set `wrena`=1, `addr`=`cnt`, `wdata`=`rxdata`, `tmr`=0.
  - If `cnt`==NBYTES-1: `cnt`=0 and go to LAST.
  - Otherwise: `cnt`=`cnt`+1 and go to RECV.
- Error (`rxerr`=1 in IDLE or RECV, with or without `rxdone`):
  - No write occurs.
  - `frame_err`=1, `cnt`=0, `tmr`=0, go to IDLE.
  - The pulse fires even in IDLE with `cnt`=0.
- RECV with no `rxdone` and no `rxerr`:
  - If `tmr`==TIMEOUT-1: `frame_err`=1, `cnt`=0, `tmr`=0, go to IDLE.
  - Otherwise `tmr`=`tmr`+1.
  - Within a cycle, `rxdone` has priority over timeout.
- LAST: `frame_valid`=1, go to FULL. An `rxdone` in this cycle is dropped and pulses `overrun`.
- FULL:
  - `rxdone` drops the byte and pulses `overrun`; no write.
  - `rxerr` is ignored.
  - `frame_ack`=1 sets `frame_valid`=0 and goes to IDLE. If `rxdone` arrives in the same cycle, the byte is still dropped with an `overrun` pulse.
- `frame_ack` outside FULL is ignored.
- IDLE has no timer; the timer never runs before the first byte.
- NBYTES=1: the first accepted byte goes directly to LAST.
- `addr` and `wdata` hold their last written values between writes.

## Timing
- Write latency: `rxdone` sampled at edge k gives `wrena`/`addr`/`wdata` valid in cycle k+1, for exactly one cycle.
- Frame completion: with the final `rxdone` at edge k, `wrena` is high in cycle k+1 and `frame_valid` is high from cycle k+2 onward. The last write therefore always finishes before `frame_valid` rises.
- `frame_ack` sampled at edge j drops `frame_valid` in cycle j+1; a byte at edge j+1 is accepted as address 0.
- Timeout: with the last accepted byte at edge k, `frame_err` is high in cycle k+TIMEOUT+1 if no byte arrived. A byte at edge k+TIMEOUT is still accepted.
- Asynchronous `rst` mid-frame immediately clears all state and outputs, including an asserted `wrena` or `frame_valid`.

## Test plan
- Six bytes 0x11..0x66, 3 idle cycles apart:
  - Six `wrena` pulses with `addr` 0..5 and matching `wdata`.
  - `frame_valid` rises 2 cycles after the 6th `rxdone`.
  - After `frame_ack`, `frame_valid` falls; a new byte 0xA5 is written at `addr` 0.
- Timeout: 3 bytes, then silence.
  - `frame_err` pulses exactly TIMEOUT+1 cycles after the 3rd `rxdone`.
  - The next byte is written at `addr` 0.
  - Repeat with a byte arriving at exactly TIMEOUT cycles: it is accepted at `addr` 3, and `frame_err` stays 0.
- `rxerr` together with the 4th `rxdone`: no write, `frame_err` pulses, the next frame restarts at `addr` 0.
- Overrun: complete a frame, send 2 bytes before `frame_ack`.
  - Two `overrun` pulses and no `wrena`.
  - `frame_valid` stays 1 until ack.
  - `rxdone` in the same cycle as `frame_ack` also pulses `overrun`.
- Reset mid-frame: assert `rst` after 2 bytes, between edges.
  - All outputs go to 0 immediately.
  - After release, a full 6-byte frame is stored at `addr` 0..5.
- NBYTES=1 build: each byte produces `wrena` at `addr` 0 followed by `frame_valid`.
